// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, result entry type and buffer depth for the multiplier datapath
package mul_pkg;

  localparam int MUL_W     = 8;
  localparam int MUL_PW    = 16;
  localparam int RES_DEPTH = 2;

  typedef struct packed {
    logic [MUL_PW-1:0] data;
    logic              ovf;
  } res_entry_t;

endpackage

// File: rtl/mul_res_fifo.sv
// rtl/mul_res_fifo.sv - 2-entry result FIFO with sticky drop flag for captures lost to a full buffer
module mul_res_fifo
  import mul_pkg::*;
#(
  parameter int DW = MUL_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          drop
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [DW-1:0] mem_q [RES_DEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q;
  logic          full, pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(RES_DEPTH));
  // A pop frees the head slot this edge, so a full buffer still accepts a same-cycle push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign drop      = drop_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      if (push && !push_ok) drop_q <= 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mul_datapath.sv
// rtl/mul_datapath.sv - repeated-addition multiplier datapath; MUL_OVF_EN adds a sticky overflow output
module mul_datapath
  import mul_pkg::*;
#(
  parameter int W  = MUL_W,
  parameter int PW = MUL_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  data_in,
  input  logic          ld_a,
  input  logic          clr_a,
  input  logic          ld_b,
  input  logic          dec_b,
  input  logic          ld_p,
  input  logic          clr_p,
  input  logic          done,
  output logic          eqz,
  output logic [PW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_drop
`ifdef MUL_OVF_EN
  ,
  output logic          ovf
`endif
);

  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] p_q, p_sum;
  logic          done_q, capture, fifo_empty;

`ifdef MUL_OVF_EN
  localparam int DW = PW + 1;
  logic          ovf_q, carry;
  logic [DW-1:0] head;
  assign {carry, p_sum} = {1'b0, p_q} + (PW+1)'(a_q);
  assign res_data       = head[PW-1:0];
  assign ovf            = head[PW];
`else
  localparam int DW = PW;
  logic [DW-1:0] head;
  assign p_sum    = p_q + PW'(a_q);
  assign res_data = head;
`endif

  assign eqz       = (b_q == '0);
  assign capture   = done && !done_q;
  assign res_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (clr_a)     a_q <= '0;
      else if (ld_a) a_q <= data_in;
      // B saturates at zero so a stray dec_b never wraps the count.
      if (ld_b)                     b_q <= data_in;
      else if (dec_b && b_q != '0)  b_q <= b_q - W'(1);
      if (clr_p)     p_q <= '0;
      else if (ld_p) p_q <= p_sum;
    end
  end

`ifdef MUL_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf_q <= 1'b0;
    else if (clr_p)            ovf_q <= 1'b0;
    else if (ld_p && carry)    ovf_q <= 1'b1;
  end
`endif

  mul_res_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
`ifdef MUL_OVF_EN
    .push_data ({ovf_q, p_q}),
`else
    .push_data (p_q),
`endif
    .pop       (res_ready),
    .head_data (head),
    .empty     (fifo_empty),
    .drop      (res_drop)
  );

endmodule

// File: tb/tb_mul_datapath.sv
// tb/tb_mul_datapath.sv - self-checking bench: vector table, scoreboard and corner sequences (MUL_OVF_EN aware)
module tb_mul_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        ld_a = 0, clr_a = 0, ld_b = 0, dec_b = 0, ld_p = 0, clr_p = 0, done = 0;
  logic        res_ready = 0;
  logic        eqz16, eqz8, valid16, valid8, drop16, drop8;
  logic [15:0] data16;
  logic [7:0]  data8;
`ifdef MUL_OVF_EN
  logic        ovf16, ovf8;
`endif

  int errs = 0;
  int checks = 0;
  int sb[$];

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  mul_datapath #(.W(8), .PW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld_a(ld_a), .clr_a(clr_a),
    .ld_b(ld_b), .dec_b(dec_b), .ld_p(ld_p), .clr_p(clr_p), .done(done),
    .eqz(eqz16), .res_data(data16), .res_valid(valid16), .res_ready(res_ready),
    .res_drop(drop16)
`ifdef MUL_OVF_EN
    , .ovf(ovf16)
`endif
  );

  mul_datapath #(.W(8), .PW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld_a(ld_a), .clr_a(clr_a),
    .ld_b(ld_b), .dec_b(dec_b), .ld_p(ld_p), .clr_p(clr_p), .done(done),
    .eqz(eqz8), .res_data(data8), .res_valid(valid8), .res_ready(res_ready),
    .res_drop(drop8)
`ifdef MUL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample at negedge; a handshake seen here completes on the following posedge.
  task automatic tick();
    int e;
    @(negedge clk);
    if (valid16 && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pop: got %0d, expected no result", data16);
      end else begin
        e = sb.pop_front();
        chk("res_data16", {16'd0, data16}, e & 32'hFFFF);
        chk("res_data8", {24'd0, data8}, e & 32'hFF);
`ifdef MUL_OVF_EN
        chk("ovf16", {31'd0, ovf16}, (e > 65535) ? 1 : 0);
        chk("ovf8", {31'd0, ovf8}, (e > 255) ? 1 : 0);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic multiply(input int a, input int b, input bit keep, input bit lat,
                          input int hold, input bit pop_at_done);
    data_in = 8'(a); ld_a = 1; clr_p = 1; tick(); ld_a = 0; clr_p = 0;
    data_in = 8'(b); ld_b = 1; tick(); ld_b = 0;
    for (int i = 0; i < b; i++) begin
      ld_p = 1; dec_b = 1; tick();
    end
    ld_p = 0; dec_b = 0;
    chk("eqz_after_count", {31'd0, eqz16}, 1);
    if (lat) chk("valid_before_done", {31'd0, valid16}, 0);
    done = 1;
    if (keep) sb.push_back(a * b);
    if (pop_at_done) res_ready = 1;
    tick();
    if (pop_at_done) res_ready = 0;
    if (lat) begin
      chk("valid_one_cycle_after_done", {31'd0, valid16}, 1);
      chk("data_one_cycle_after_done", {16'd0, data16}, 32'(a * b));
    end
    for (int i = 1; i < hold; i++) tick();
    done = 0;
    tick();
  endtask

  task automatic drain();
    res_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    res_ready = 0;
    chk("drained_valid", {31'd0, valid16}, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 rst_n = 1;
    sb.delete();
    tick();
  endtask

  initial begin
    vecs[0] = '{5, 3, 15};
    vecs[1] = '{0, 7, 0};
    vecs[2] = '{7, 0, 0};
    vecs[3] = '{255, 255, 65025};
    vecs[4] = '{1, 1, 1};
    vecs[5] = '{12, 11, 132};
    vecs[6] = '{255, 2, 510};

    #12;
    chk("reset_eqz", {31'd0, eqz16}, 1);
    chk("reset_valid", {31'd0, valid16}, 0);
    chk("reset_data", {16'd0, data16}, 0);
    rst_n = 1;
    tick();

    multiply(5, 3, 1, 1, 3, 0);
    chk("one_capture_while_done_high", 32'(sb.size()), 1);
    drain();

    res_ready = 1;
    foreach (vecs[k]) begin
      multiply(vecs[k].a, vecs[k].b, 1, 0, 1, 0);
      tick();
      chk("vec_consumed", 32'(sb.size()), 0);
    end
    res_ready = 0;
    chk("vec_table_product", 32'(vecs[6].a * vecs[6].b) & 32'hFF, 254);

    // Precedence: clr_p beats ld_p, old A used on ld_a+ld_p, clr_a beats ld_a.
    data_in = 4; ld_a = 1; clr_p = 1; tick(); ld_a = 0; clr_p = 0;
    ld_p = 1; tick(); clr_p = 1; tick(); clr_p = 0; ld_p = 0;
    done = 1; sb.push_back(0); tick(); done = 0; tick();
    drain();
    ld_p = 1; data_in = 9; ld_a = 1; tick(); ld_a = 0; tick(); ld_p = 0;
    done = 1; sb.push_back(13); tick(); done = 0; tick();
    drain();
    data_in = 7; ld_a = 1; clr_a = 1; clr_p = 1; tick(); ld_a = 0; clr_a = 0; clr_p = 0;
    ld_p = 1; tick(); ld_p = 0;
    done = 1; sb.push_back(0); tick(); done = 0; tick();
    drain();

    data_in = 7; ld_b = 1; dec_b = 1; tick(); ld_b = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("ldb_over_decb_not_zero", {31'd0, eqz16}, 0);
    tick();
    chk("ldb_over_decb_reaches_zero", {31'd0, eqz16}, 1);
    tick();
    chk("decb_at_zero_holds", {31'd0, eqz16}, 1);
    dec_b = 0;

    // Backpressure: third product lost, drop sticks.
    multiply(2, 3, 1, 0, 1, 0);
    multiply(2, 5, 1, 0, 1, 0);
    chk("bp_no_drop_yet", {31'd0, drop16}, 0);
    multiply(3, 4, 0, 0, 1, 0);
    chk("bp_drop", {31'd0, drop16}, 1);
    chk("bp_drop8", {31'd0, drop8}, 1);
    chk("bp_head", {16'd0, data16}, 6);
    drain();
    chk("bp_drop_sticky", {31'd0, drop16}, 1);

    do_reset();
    chk("drop_cleared_by_reset", {31'd0, drop16}, 0);

    // Full buffer, capture and pop on the same edge.
    multiply(2, 3, 1, 0, 1, 0);
    multiply(2, 5, 1, 0, 1, 0);
    multiply(3, 4, 1, 0, 1, 1);
    chk("sim_no_drop", {31'd0, drop16}, 0);
    chk("sim_head", {16'd0, data16}, 10);
    drain();

    // Asynchronous reset mid-accumulate with a result waiting.
    multiply(2, 3, 1, 0, 1, 0);
    data_in = 5; ld_a = 1; tick(); ld_a = 0;
    data_in = 3; ld_b = 1; clr_p = 1; tick(); ld_b = 0; clr_p = 0;
    ld_p = 1; dec_b = 1; tick();
    #2 rst_n = 0;
    #1;
    chk("async_eqz", {31'd0, eqz16}, 1);
    chk("async_eqz8", {31'd0, eqz8}, 1);
    chk("async_valid", {31'd0, valid16}, 0);
    chk("async_valid8", {31'd0, valid8}, 0);
    chk("async_data", {16'd0, data16}, 0);
    ld_p = 0; dec_b = 0;
    sb.delete();
    #3 rst_n = 1;
    tick();
    ld_p = 1; tick(); ld_p = 0;
    done = 1; sb.push_back(0); tick(); done = 0; tick();
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
